change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Downstream stage of the vending controller. Takes the change amount the controller computes
//  at delivery and pays it out as physical coins (5 zl, 2 zl, 1 zl hoppers) using a greedy
//  largest-coin-first policy. Drives one eject pulse per coin, waits for the hopper's coin-seen
//  acknowledge, and falls back to smaller coins when a hopper is empty or stops responding.
//  Reports paid and remaining totals for the 7-segment change display (digit2/digit3).
// PARAMETERS
//  AMT_W        8   width of all money quantities (zl)
//  PULSE_CYCLES 4   eject pulse length, cycles (>=1)
//  GAP_CYCLES   2   idle cycles after each acknowledged coin (>=1)
//  ACK_TIMEOUT  16  cycles allowed for coin_ack after the pulse ends (>=1)
// PORTS
//  clk           in   1      system clock
//  reset         in   1      synchronous, active-high
//  start         in   1      request payout; sampled only while ready=1
//  change_amt    in   AMT_W  amount to pay; captured when start && ready
//  hopper_empty  in   3      level; [0]=1zl, [1]=2zl, [2]=5zl (same mapping as Money_in)
//  coin_ack      in   1      1-cycle pulse from the coin-exit sensor
//  ready         out  1      1 in IDLE only
//  busy          out  1      ~ready
//  eject         out  3      one-hot eject pulse, bit mapping as hopper_empty
//  done          out  1      1-cycle pulse: payout complete (remaining==0)
//  error         out  1      1-cycle pulse: payout aborted; remaining > 0
//  paid          out  AMT_W  running total ejected and acked for the current request
//  remaining     out  AMT_W  change still owed
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high. Clock and reset ports are clk and reset.
//  Reset: state=IDLE; ready=1; busy=0; eject=0; done=0; error=0; paid=0; remaining=0; dead mask=0.
//   Reset mid-pulse drops eject on the same edge.
//  FSM states:
//   IDLE: on start, load remaining=change_amt and paid=0.
//    - change_amt==0 -> DONE.
//    - otherwise -> SELECT.
//    - start while busy is ignored; there is no queueing.
//   SELECT: pick d = largest of {5,2,1} with remaining>=d && !hopper_empty[d] && !dead[d].
//    - d found -> PULSE.
//    - remaining==0 -> DONE.
//    - no d -> FAULT.
//   PULSE: eject[d]=1 for exactly PULSE_CYCLES cycles, then -> WAIT_ACK.
//   WAIT_ACK: coin_ack -> remaining-=d, paid+=d, -> GAP.
//    - Timeout after ACK_TIMEOUT cycles with no coin_ack -> set dead[d] (sticky until reset) -> SELECT.
//    - A coin_ack outside WAIT_ACK (including during PULSE) is ignored.
//   GAP: hold GAP_CYCLES cycles -> SELECT.
//   DONE: done=1 for one cycle -> IDLE.
//   FAULT: error=1 for one cycle -> IDLE. paid and remaining hold until the next start.
//  Latency: start accepted at edge N; SELECT in cycle N+1; eject asserted from cycle N+2.
//   change_amt==0 gives done in cycle N+1.
//  Arithmetic: unsigned AMT_W. Subtraction cannot underflow because d<=remaining is checked in SELECT.
//   paid+remaining equals change_amt at all times after start.
//  hopper_empty is sampled only in SELECT. A change during a pulse does not abort the coin.
//  eject is never multi-hot; at most one bit is high in any cycle.
// STRUCTURE
//  vending_pkg (shared): COIN_1/2/5 bit indices, coin values {1,2,5}, dispenser state encoding.
//   The controller uses the same index constants for Money_in.
//  Sub-module dispense_timer: loadable down-counter with zero flag. It serves PULSE, WAIT_ACK and GAP.
//   Width is clog2(max(PULSE_CYCLES, GAP_CYCLES, ACK_TIMEOUT)+1).
//  Top: FSM, greedy selector (combinational), paid/remaining registers.
// TESTING
//  1. change_amt=8, all hoppers full, ack 3 cycles after each pulse:
//     eject 5,2,1 in order; done; paid=8, remaining=0.
//  2. change_amt=0: done in cycle N+1; eject never asserted; paid=0.
//  3. hopper_empty[2]=1, change_amt=7: eject 2,2,2,1; done; paid=7.
//  4. change_amt=4, 2zl hopper never acks:
//     one 2zl pulse; timeout after 16 cycles; dead[1] set; then 1,1,1,1; done, paid=4.
//     A second request of 2: eject 1,1; dead persists.
//  5. change_amt=6, hopper_empty=3'b011, 5zl acks:
//     eject 5, then no coin fits; error pulse; paid=5, remaining=1.
//  6. Reset asserted in 2nd PULSE cycle:
//     eject=0 next cycle, ready=1, paid=remaining=0, dead cleared; start during busy is ignored.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared coin indices, coin values and dispenser state encoding for the vending datapath.
// Coin bit indices match the Money_in mapping used by the controller.
package change_dispenser_pkg;

    localparam int unsigned NUM_COINS = 3;
    localparam int unsigned COIN_W    = 2;

    localparam int unsigned COIN_1 = 0;
    localparam int unsigned COIN_2 = 1;
    localparam int unsigned COIN_5 = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_PULSE    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5,
        ST_FAULT    = 3'd6
    } disp_state_t;

    // Face value in zl of the coin at a hopper index.
    function automatic int unsigned coin_value(input logic [COIN_W-1:0] idx);
        case (idx)
            2'd0:    coin_value = 1;
            2'd1:    coin_value = 2;
            2'd2:    coin_value = 5;
            default: coin_value = 0;
        endcase
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        max3 = (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/change_dispenser_timer.sv
// Loadable down-counter with a registered zero flag; times pulse, ack window and gap.
// Saturates at zero; load has priority over decrement.
module change_dispenser_timer #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = load_val;
        end else if (dec && (count != '0)) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            zero  <= 1'b1;
        end else begin
            count <= count_nxt;
            zero  <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin payout stage: ejects 5/2/1 zl coins one at a time, waits for the exit sensor,
// and retires hoppers that stop acknowledging. Reports paid/remaining for the change display.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned AMT_W        = 8,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned ACK_TIMEOUT  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AMT_W-1:0]     change_amt,
    input  logic [NUM_COINS-1:0] hopper_empty,
    input  logic                 coin_ack,
    output logic                 ready,
    output logic                 busy,
    output logic [NUM_COINS-1:0] eject,
    output logic                 done,
    output logic                 error,
    output logic [AMT_W-1:0]     paid,
    output logic [AMT_W-1:0]     remaining
);

    localparam int unsigned TMR_MAX = max3(PULSE_CYCLES, GAP_CYCLES, ACK_TIMEOUT);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    disp_state_t state;
    disp_state_t next_state;

    logic [COIN_W-1:0]    cur_coin;
    logic [COIN_W-1:0]    coin_nxt;
    logic [NUM_COINS-1:0] dead;
    logic [AMT_W-1:0]     cur_val;

    logic                 sel_found;
    logic [COIN_W-1:0]    sel_idx;

    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic                 tmr_dec;
    logic                 tmr_zero;

    logic                 ready_d;
    logic                 busy_d;
    logic [NUM_COINS-1:0] eject_d;
    logic                 done_d;
    logic                 error_d;

    assign cur_val = AMT_W'(coin_value(cur_coin));

    // Greedy pick: ascending scan so the largest usable coin wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < int'(NUM_COINS); i++) begin
            if ((remaining >= AMT_W'(coin_value(COIN_W'(i)))) &&
                !hopper_empty[i] && !dead[i]) begin
                sel_found = 1'b1;
                sel_idx   = COIN_W'(i);
            end
        end
    end

    change_dispenser_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (change_amt == '0) ? ST_DONE : ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (remaining == '0) begin
                    next_state = ST_DONE;
                end else if (sel_found) begin
                    next_state = ST_PULSE;
                end else begin
                    next_state = ST_FAULT;
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    next_state = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (coin_ack) begin
                    next_state = ST_GAP;
                end else if (tmr_zero) begin
                    next_state = ST_SELECT;
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    next_state = ST_SELECT;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            ST_FAULT: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Output and timer control decode; outputs are registered from the next state.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b1;
        coin_nxt = (state == ST_SELECT) ? sel_idx : cur_coin;
        ready_d  = (next_state == ST_IDLE);
        busy_d   = (next_state != ST_IDLE);
        done_d   = (next_state == ST_DONE);
        error_d  = (next_state == ST_FAULT);
        eject_d  = '0;
        if (next_state == ST_PULSE) begin
            eject_d = NUM_COINS'(1) << coin_nxt;
        end
        if (next_state != state) begin
            case (next_state)
                ST_PULSE: begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(PULSE_CYCLES - 1);
                end
                ST_WAIT_ACK: begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(ACK_TIMEOUT - 1);
                end
                ST_GAP: begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(GAP_CYCLES - 1);
                end
                default: begin
                    tmr_load = 1'b0;
                    tmr_val  = '0;
                end
            endcase
        end
        if (tmr_load) begin
            tmr_dec = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            eject <= '0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            ready <= ready_d;
            busy  <= busy_d;
            eject <= eject_d;
            done  <= done_d;
            error <= error_d;
        end
    end

    // Money registers and the sticky dead-hopper mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            paid      <= '0;
            remaining <= '0;
            dead      <= '0;
            cur_coin  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= change_amt;
                        paid      <= '0;
                    end
                end
                ST_SELECT: begin
                    if (sel_found) begin
                        cur_coin <= sel_idx;
                    end
                end
                ST_WAIT_ACK: begin
                    if (coin_ack) begin
                        remaining <= remaining - cur_val;
                        paid      <= paid + cur_val;
                    end else if (tmr_zero) begin
                        dead[cur_coin] <= 1'b1;
                    end
                end
                default: begin
                    paid <= paid;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser with a hopper responder and a
// greedy payout reference model.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] change_amt;
    logic [2:0] hopper_empty;
    logic       coin_ack;
    logic       ready;
    logic       busy;
    logic [2:0] eject;
    logic       done;
    logic       error;
    logic [7:0] paid;
    logic [7:0] remaining;

    change_dispenser dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .change_amt   (change_amt),
        .hopper_empty (hopper_empty),
        .coin_ack     (coin_ack),
        .ready        (ready),
        .busy         (busy),
        .eject        (eject),
        .done         (done),
        .error        (error),
        .paid         (paid),
        .remaining    (remaining)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit [2:0] jammed;
    bit [2:0] m_dead;
    int       ack_delay;
    bit       spurious;
    int       obs_q[$];
    int       exp_q[$];
    int       multi_hot;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [2:0] e);
        return e[2] ? 2 : (e[1] ? 1 : 0);
    endfunction

    // Reference: greedy 5/2/1 payout; a jammed hopper gets one pulse and is then retired.
    task automatic model_payout(input int amt, input bit [2:0] empty,
                                output int e_paid, output int e_rem, output bit e_done);
        int vals[3];
        int d;
        vals[0] = 1; vals[1] = 2; vals[2] = 5;
        e_rem  = amt;
        e_paid = 0;
        e_done = 1'b0;
        exp_q.delete();
        for (int guard = 0; guard < 1000; guard++) begin
            if (e_rem == 0) begin
                e_done = 1'b1;
                break;
            end
            d = -1;
            for (int i = 2; i >= 0; i--) begin
                if (d < 0 && vals[i] <= e_rem && !empty[i] && !m_dead[i]) d = i;
            end
            if (d < 0) break;
            exp_q.push_back(d);
            if (jammed[d]) begin
                m_dead[d] = 1'b1;
            end else begin
                e_rem  -= vals[d];
                e_paid += vals[d];
            end
        end
    endtask

    // Eject monitor: records each completed pulse and its length.
    initial begin
        logic [2:0] prev;
        int         plen;
        int         pidx;
        bit         paborted;
        prev = '0; plen = 0; pidx = 0; paborted = 1'b0;
        forever begin
            @(negedge clk);
            if ($countones(eject) > 1) multi_hot++;
            if (eject != '0) begin
                if (prev == '0) begin
                    plen = 0;
                    pidx = onehot_idx(eject);
                    paborted = 1'b0;
                end
                plen++;
                if (reset) paborted = 1'b1;
            end else if (prev != '0) begin
                if (!paborted && !reset) begin
                    obs_q.push_back(pidx);
                    check_val("pulse_len", plen, 4);
                end
                paborted = 1'b0;
            end
            prev = eject;
        end
    end

    // Hopper responder: optional spurious ack mid-pulse, real ack after the pulse unless jammed.
    initial begin
        int hid;
        int n;
        coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (eject != '0 && !reset) begin
                hid = onehot_idx(eject);
                if (spurious) begin
                    coin_ack = 1'b1;
                    @(negedge clk);
                    coin_ack = 1'b0;
                end
                n = 0;
                while (eject != '0 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (!jammed[hid] && !reset) begin
                    repeat (ack_delay) @(negedge clk);
                    coin_ack = 1'b1;
                    @(negedge clk);
                    coin_ack = 1'b0;
                end
            end
        end
    end

    task automatic run_txn(input int amt, input bit [2:0] empty, input bit poke);
        int e_paid, e_rem, cyc, nobs;
        bit e_done;
        model_payout(amt, empty, e_paid, e_rem, e_done);
        obs_q.delete();
        multi_hot    = 0;
        hopper_empty = empty;
        change_amt   = 8'(amt);
        start        = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        change_amt = 8'($urandom);
        check_val("busy_after_start", busy, 1);
        if (amt == 0) check_val("zero_done_latency", done, 1);
        cyc = 0;
        forever begin
            if (done || error || cyc >= 5000) break;
            if (cyc == 1 && exp_q.size() > 0)
                check_val("eject_latency", eject, 32'(1) << exp_q[0]);
            if (poke && cyc == 6) start = 1'b1;
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        start = 1'b0;
        check_val("completed", done | error, 1);
        check_val("done", done, e_done);
        check_val("error", error, !e_done);
        check_val("paid", paid, e_paid);
        check_val("remaining", remaining, e_rem);
        check_val("ready_in_end", ready, 0);
        @(negedge clk);
        check_val("ready_after", ready, 1);
        check_val("pulse_count", obs_q.size(), exp_q.size());
        nobs = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < nobs; i++) check_val("coin_seq", obs_q[i], exp_q[i]);
        check_val("one_hot", multi_hot, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        m_dead = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; change_amt = '0; hopper_empty = '0;
        jammed = '0; m_dead = '0; ack_delay = 3; spurious = 1'b0; multi_hot = 0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_eject", eject, 0);
        check_val("rst_done", done, 0);
        check_val("rst_error", error, 0);
        check_val("rst_paid", paid, 0);
        check_val("rst_remaining", remaining, 0);
        reset = 1'b0;
        @(negedge clk);

        run_txn(8, 3'b000, 1'b0);
        run_txn(0, 3'b000, 1'b0);
        run_txn(7, 3'b100, 1'b0);
        jammed = 3'b010;
        run_txn(4, 3'b000, 1'b0);
        jammed = 3'b000;
        run_txn(2, 3'b000, 1'b0);
        run_txn(6, 3'b011, 1'b0);

        // Reset during the second pulse cycle; dead[1] is still set from the jam above.
        hopper_empty = '0;
        change_amt   = 8'd8;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (eject == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("pulse_seen", eject != '0, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("midrst_eject", eject, 0);
        check_val("midrst_ready", ready, 1);
        check_val("midrst_paid", paid, 0);
        check_val("midrst_remaining", remaining, 0);
        @(negedge clk);
        reset  = 1'b0;
        m_dead = '0;
        repeat (20) @(negedge clk);
        run_txn(2, 3'b000, 1'b1);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) do_reset();
            jammed    = ($urandom_range(0, 5) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            ack_delay = $urandom_range(0, 12);
            spurious  = ($urandom_range(0, 3) == 0);
            run_txn($urandom_range(0, 40), 3'($urandom), ($urandom_range(0, 2) == 0));
        end
        spurious = 1'b0;
        jammed   = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
